// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Holds the receiver state encoding, default frame geometry and the odd-parity helper.
package uart_pkg;

    localparam int DATA_BITS_DEF  = 8;
    localparam int OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Expected odd-parity bit. Callers zero-extend their word; the zero bits do not change the XOR.
    function automatic logic odd_parity(input logic [31:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side output bundle from uart_rx to its downstream consumer (FIFO or bus bridge).
interface uart_rx_if import uart_pkg::*; #(
    parameter int DATA_BITS = DATA_BITS_DEF
) ();

    // rx_valid is a one-clock strobe with no ready: the consumer must take the word on that
    // cycle. rx_data, parity_error and framing_error stay stable until the next rx_valid.
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_error;
    logic                 framing_error;
    logic                 rx_busy;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_error,
        output framing_error,
        output rx_busy
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input parity_error,
        input framing_error,
        input rx_busy
    );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// The reset value matches the line's idle level so reset never looks like a start bit.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/optional odd parity/stop framing, LSB first.
// Each completed frame, errored or not, produces one rx_valid strobe with its error flags.
module uart_rx import uart_pkg::*; #(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_tick,
    input  logic       rx_pin,
    input  logic       parity_enable,
    uart_rx_if.master  rx_out,
    output rx_state_t  dbg_state
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_index;
    logic [DATA_BITS-1:0] shift;
    logic                 par_en;
    logic                 par_bit;
    logic                 stop_bit;
    logic                 done;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 busy_q;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx_pin),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_index <= '0;
            shift     <= '0;
            par_en    <= 1'b0;
            par_bit   <= 1'b0;
            stop_bit  <= 1'b1;
            done      <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;

            // Frame publication runs one clock after the stop sample, independent of ticks.
            if (done) begin
                done    <= 1'b0;
                valid_q <= 1'b1;
                data_q  <= shift;
                ferr_q  <= ~stop_bit;
                perr_q  <= par_en & (par_bit != odd_parity(32'(shift)));
                busy_q  <= 1'b0;
            end

            // A new start detected on the publish cycle must win over the busy clear above.
            if (sample_tick) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state  <= START;
                            cnt    <= '0;
                            busy_q <= 1'b1;
                            par_en <= parity_enable;
                        end
                    end
                    START: begin
                        if (cnt == CNT_HALF) begin
                            cnt <= '0;
                            if (rx_s) begin
                                state  <= IDLE;
                                busy_q <= 1'b0;
                            end else begin
                                state     <= DATA;
                                bit_index <= '0;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    DATA: begin
                        if (cnt == CNT_FULL) begin
                            cnt   <= '0;
                            shift <= {rx_s, shift[DATA_BITS-1:1]};
                            if (bit_index == IDX_LAST) begin
                                state <= par_en ? PARITY : STOP;
                            end else begin
                                bit_index <= bit_index + IDX_W'(1);
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    PARITY: begin
                        if (cnt == CNT_FULL) begin
                            cnt     <= '0;
                            par_bit <= rx_s;
                            state   <= STOP;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    STOP: begin
                        if (cnt == CNT_FULL) begin
                            cnt      <= '0;
                            stop_bit <= rx_s;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign rx_out.rx_data       = data_q;
    assign rx_out.rx_valid      = valid_q;
    assign rx_out.parity_error  = perr_q;
    assign rx_out.framing_error = ferr_q;
    assign rx_out.rx_busy       = busy_q;
    assign dbg_state            = state;

endmodule
